// File: rtl/grf_scoreboard.sv
// grf_scoreboard: 32x32 general register file with write-through reads,
// plus a per-register pending-write scoreboard that refuses issue of
// instructions whose sources are not yet written back, or whose
// destination already has the maximum number of writes in flight.
module grf_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic [4:0]  A3,
  input  logic        WE3,
  input  logic [31:0] WD3,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic [4:0]  issue_dst,
  input  logic        issue_we,
  input  logic        flush,
  output logic        stall,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      regs [32];
  logic [CNT_W-1:0] pend [32];

  logic wr_en;
  logic haz_rs;
  logic haz_rt;
  logic dst_full;
  logic inc_en;
  logic underflow;

  // Register 0 is never a real write target; all write-side logic uses wr_en.
  assign wr_en = WE3 && (A3 != 5'd0);

  // Write-through read ports; register 0 always reads zero.
  always_comb begin
    if (A1 == 5'd0)                RD1 = 32'd0;
    else if (wr_en && (A3 == A1))  RD1 = WD3;
    else                           RD1 = regs[A1];
    if (A2 == 5'd0)                RD2 = 32'd0;
    else if (wr_en && (A3 == A2))  RD2 = WD3;
    else                           RD2 = regs[A2];
  end

  // Hazard detection. A source with exactly one pending write that is being
  // written back this cycle is satisfied by the write-through path.
  always_comb begin
    haz_rs = issue_use_rs && (issue_rs != 5'd0) && (pend[issue_rs] != '0) &&
             !((pend[issue_rs] == CNT_ONE) && wr_en && (A3 == issue_rs));
    haz_rt = issue_use_rt && (issue_rt != 5'd0) && (pend[issue_rt] != '0) &&
             !((pend[issue_rt] == CNT_ONE) && wr_en && (A3 == issue_rt));
    dst_full = issue_we && (issue_dst != 5'd0) && (pend[issue_dst] == CNT_MAX);
    stall = issue_valid && !flush && !reset && (haz_rs || haz_rt || dst_full);
    inc_en = issue_valid && !stall && issue_we && (issue_dst != 5'd0);
    // A decrement at zero is an error only when no increment cancels it.
    underflow = !flush && wr_en && (pend[A3] == '0) &&
                !(inc_en && (issue_dst == A3));
  end

  // Register file storage; flush does not block write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

  // Pending-write counters, one per register; entry 0 stays at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset || flush || (i == 0)) begin
        pend[i] <= '0;
      end else begin
        if (inc_en && (issue_dst == 5'(i)) && !(wr_en && (A3 == 5'(i)))) begin
          pend[i] <= pend[i] + CNT_ONE;
        end else if (wr_en && (A3 == 5'(i)) && !(inc_en && (issue_dst == 5'(i))) &&
                     (pend[i] != '0)) begin
          pend[i] <= pend[i] - CNT_ONE;
        end
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)          sb_err <= 1'b0;
    else if (underflow) sb_err <= 1'b1;
  end

endmodule
